// File: rtl/bola_nave_if.sv
// bola_nave_if: control inputs and shot outputs of the player projectile generator.
interface bola_nave_if;
    logic       pausa, reiniciarJogo, disparo, acerto;
    logic [9:0] nave_x, nave_y;
    logic [9:0] bola_nave_x, bola_nave_y;
    logic       ativa, evento_tiro;
    logic [7:0] disparos;
    modport master (
        output pausa, reiniciarJogo, disparo, acerto, nave_x, nave_y,
        input  bola_nave_x, bola_nave_y, ativa, evento_tiro, disparos
    );
    modport slave (
        input  pausa, reiniciarJogo, disparo, acerto, nave_x, nave_y,
        output bola_nave_x, bola_nave_y, ativa, evento_tiro, disparos
    );
endinterface

// File: rtl/bola_nave.sv
// bola_nave: launches one shot from the ship on a fire press, moves it up and retires it at the top or on a hit.
module bola_nave #(
    parameter int CLK_DIV      = 320000,
    parameter int VEL          = 4,
    parameter int Y_TOPO       = 0,
    parameter int LARGURA_NAVE = 30,
    parameter int RECARGA      = 8
) (
    input logic CLOCK_50,
    input logic reset_n,
    bola_nave_if.slave b
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    typedef enum logic [1:0] {OCIOSA, VOANDO, ESPERA} estado_t;
    estado_t estado, proximo;
    logic [DW-1:0] div;
    logic [2:0] sinc, pronto;
    logic [9:0] x, y;
    logic [7:0] disparos, espera;
    logic ativa, evento, tick, tiro, lanca, fim;
    assign tick  = !b.pausa && div == DW'(CLK_DIV - 1);
    // pronto keeps a button already held through reset from looking like a fresh press
    assign tiro  = !b.pausa && pronto[2] && sinc[1] && !sinc[2];
    assign lanca = estado == OCIOSA && tiro && b.nave_y >= 10'(Y_TOPO + VEL + 1);
    assign fim   = estado == VOANDO && !b.pausa && (b.acerto || (tick && y < 10'(Y_TOPO + VEL)));
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) estado <= OCIOSA;
        else estado <= b.reiniciarJogo ? OCIOSA : proximo;
    always_comb begin
        proximo = estado;
        if (lanca) proximo = VOANDO;
        else if (fim) proximo = ESPERA;
        else if (estado == ESPERA && tick && espera <= 8'd1) proximo = OCIOSA;
    end
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) {sinc, pronto, div, x, y, ativa, evento, disparos, espera} <= '0;
        else if (b.reiniciarJogo) {sinc, pronto, div, x, y, ativa, evento, disparos, espera} <= '0;
        else begin
            sinc   <= {sinc[1:0], b.disparo};
            pronto <= {pronto[1:0], 1'b1};
            evento <= lanca;
            if (!b.pausa) div <= tick ? '0 : div + DW'(1);
            if (lanca) begin
                x     <= b.nave_x + 10'(LARGURA_NAVE / 2);
                y     <= b.nave_y - 10'd1;
                ativa <= 1'b1;
                if (disparos != 8'hff) disparos <= disparos + 8'd1;
            end else if (fim) begin
                x      <= '0;
                y      <= '0;
                ativa  <= 1'b0;
                espera <= 8'(RECARGA);
            end else if (estado == VOANDO && tick) y <= y - 10'(VEL);
            else if (estado == ESPERA && tick && espera != 8'd0) espera <= espera - 8'd1;
        end
    assign b.bola_nave_x = x;
    assign b.bola_nave_y = y;
    assign b.ativa       = ativa;
    assign b.evento_tiro = evento;
    assign b.disparos    = disparos;
endmodule

// File: tb/tb_bola_nave.sv
// tb_bola_nave: directed checks of launch latency, flight, retire, cooldown, pause, saturation and restart.
module tb_bola_nave;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0;
    bola_nave_if b();
    bola_nave #(.CLK_DIV(4), .VEL(4), .Y_TOPO(0), .LARGURA_NAVE(30), .RECARGA(2)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .b(b)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_y(input int yv, input int budget);
        int k = 0;
        while (int'(b.bola_nave_y) != yv && k < budget) begin step(1); k++; end
        check("wait_y", int'(b.bola_nave_y), yv);
    endtask
    task automatic wait_ativa(input int budget);
        int k = 0;
        while (b.ativa !== 1'b1 && k < budget) begin step(1); k++; end
        check("wait_ativa", int'(b.ativa), 1);
    endtask
    initial begin
        int last, k;
        b.pausa = 0; b.reiniciarJogo = 0; b.disparo = 1; b.acerto = 1;
        b.nave_x = 10'd100; b.nave_y = 10'd400;
        #22;
        check("rst_x", int'(b.bola_nave_x), 0);
        check("rst_y", int'(b.bola_nave_y), 0);
        check("rst_ativa", int'(b.ativa), 0);
        check("rst_evento", int'(b.evento_tiro), 0);
        check("rst_disparos", int'(b.disparos), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(10);
        check("held_no_launch", int'(b.ativa), 0);
        check("held_disparos", int'(b.disparos), 0);
        b.disparo = 0; b.acerto = 0;
        step(4);
        // launch latency and load values
        b.disparo = 1;
        step(1); check("lat_edge1", int'(b.ativa), 0);
        step(1); check("lat_edge2", int'(b.ativa), 0);
        step(1);
        check("launch_ativa", int'(b.ativa), 1);
        check("launch_x", int'(b.bola_nave_x), 115);
        check("launch_y", int'(b.bola_nave_y), 399);
        check("launch_evento", int'(b.evento_tiro), 1);
        check("launch_disparos", int'(b.disparos), 1);
        b.disparo = 0;
        step(1);
        check("evento_one_cycle", int'(b.evento_tiro), 0);
        wait_y(395, 8);
        // free flight to the top
        last = 0; k = 0;
        while (b.ativa === 1'b1 && k < 500) begin last = int'(b.bola_nave_y); step(1); k++; end
        check("retire_last_y", last, 3);
        check("retire_x", int'(b.bola_nave_x), 0);
        check("retire_y", int'(b.bola_nave_y), 0);
        b.disparo = 1; step(3);
        check("fire_cooldown_early", int'(b.ativa), 0);
        b.disparo = 0; step(2);
        b.disparo = 1; step(3);
        check("fire_cooldown_last", int'(b.ativa), 0);
        b.disparo = 0; step(2);
        b.disparo = 1; step(3);
        check("fire_after_cooldown", int'(b.ativa), 1);
        check("disparos_2", int'(b.disparos), 2);
        b.disparo = 0;
        // hit coinciding with a tick
        wait_y(251, 600);
        step(3);
        b.acerto = 1; step(1); b.acerto = 0;
        check("hit_ativa", int'(b.ativa), 0);
        check("hit_y", int'(b.bola_nave_y), 0);
        check("hit_x", int'(b.bola_nave_x), 0);
        b.disparo = 1; step(3);
        check("fire_in_recarga", int'(b.ativa), 0);
        b.disparo = 0; step(7);
        b.disparo = 1; step(3);
        check("relaunch", int'(b.ativa), 1);
        check("disparos_3", int'(b.disparos), 3);
        b.disparo = 0;
        // pause mid-flight
        wait_y(395, 8);
        step(1);
        b.pausa = 1; step(4);
        b.disparo = 1; step(15);
        b.disparo = 0; step(31);
        check("pause_y", int'(b.bola_nave_y), 395);
        check("pause_ativa", int'(b.ativa), 1);
        check("pause_disparos", int'(b.disparos), 3);
        b.pausa = 0; step(2);
        check("resume_hold", int'(b.bola_nave_y), 395);
        step(1);
        check("resume_move", int'(b.bola_nave_y), 391);
        b.acerto = 1; step(1); b.acerto = 0;
        check("hit2_ativa", int'(b.ativa), 0);
        step(12);
        // launch guard on low ship
        b.nave_y = 10'd4; b.disparo = 1; step(4);
        check("low_ship_ativa", int'(b.ativa), 0);
        check("low_ship_disparos", int'(b.disparos), 3);
        b.disparo = 0; b.nave_y = 10'd400; step(3);
        // counter saturation
        for (int i = 0; i < 256; i++) begin
            b.disparo = 1; wait_ativa(8); b.disparo = 0;
            check("disparos_sat", int'(b.disparos), (i + 4 > 255) ? 255 : i + 4);
            b.acerto = 1; step(1); b.acerto = 0; step(12);
        end
        // restart mid-flight
        b.disparo = 1; wait_ativa(8); b.disparo = 0; step(2);
        b.reiniciarJogo = 1; step(1); b.reiniciarJogo = 0;
        check("restart_ativa", int'(b.ativa), 0);
        check("restart_x", int'(b.bola_nave_x), 0);
        check("restart_y", int'(b.bola_nave_y), 0);
        check("restart_disparos", int'(b.disparos), 0);
        check("restart_evento", int'(b.evento_tiro), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
